// File: rtl/lane_descrambler_pkg.sv
// Shared types and keystream helpers for the two-lane descrambler.
package lane_descrambler_pkg;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/lane_descrambler_lfsr.sv
// Keystream generator: holds the LFSR and resolves the reset/sync/step priorities.
module lane_descrambler_lfsr
    import lane_descrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              sync,
    output logic [LFSR_W-1:0] key
);

    logic [LFSR_W-1:0] lfsr;

    // A sync beat is keyed from SEED, so the effective key bypasses the register.
    assign key = sync ? SEED : lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (sync) begin
            lfsr <= step ? lfsr_next(SEED) : SEED;
        end else if (step) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/lane_descrambler.sv
// Two-lane XOR descrambler with a 2-entry output/skid buffer.
// Optional parity checking is enabled by defining LANE_DESCRAMBLER_PARITY_CHECK_EN.
module lane_descrambler
    import lane_descrambler_pkg::*;
#(
    parameter int                WIDTH = 8,
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_w0,
    input  logic [WIDTH-1:0] in_w1,
    input  logic [1:0]       in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_u0,
    output logic [WIDTH-1:0] out_u1,
    output logic [7:0]       err_cnt
);

    buf_state_t        state;
    logic [LFSR_W-1:0] key;
    logic [WIDTH-1:0]  u0;
    logic [WIDTH-1:0]  u1;
    logic [WIDTH-1:0]  skid_u0;
    logic [WIDTH-1:0]  skid_u1;
    logic              push;
    logic              pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    lane_descrambler_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .step (push),
        .sync (sync),
        .key  (key)
    );

    assign u0 = in_w0 ^ key[WIDTH-1:0];
    assign u1 = in_w1 ^ key[WIDTH+7:8];

    // in_ready and out_valid are registered alongside the state they mirror.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_u0    <= '0;
            out_u1    <= '0;
            skid_u0   <= '0;
            skid_u1   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        out_u0    <= u0;
                        out_u1    <= u1;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_u0 <= u0;
                        out_u1 <= u1;
                    end else if (push) begin
                        skid_u0  <= u0;
                        skid_u1  <= u1;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        out_u0   <= skid_u0;
                        out_u1   <= skid_u1;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

`ifdef LANE_DESCRAMBLER_PARITY_CHECK_EN
    logic [1:0] lane_err;
    logic [8:0] err_sum;

    assign lane_err = {(^u1) != in_par[1], (^u0) != in_par[0]};
    assign err_sum  = {1'b0, err_cnt} + 9'(lane_err[0]) + 9'(lane_err[1]);

    // Saturating count of lanes whose recovered data fails even parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (push) begin
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end
`else
    logic unused_par;

    assign unused_par = ^in_par;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_lane_descrambler.sv
// Scoreboard bench for lane_descrambler; follows LANE_DESCRAMBLER_PARITY_CHECK_EN if defined.
module tb_lane_descrambler;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_w0;
    logic [7:0] in_w1;
    logic [1:0] in_par;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_u0;
    logic [7:0] out_u1;
    logic [7:0] err_cnt;

    int          total = 0;
    int          bad = 0;
    logic [15:0] sb[$];
    logic [15:0] model_lfsr = SEED;
    int          model_err = 0;
    bit          rand_mode = 1'b0;

    lane_descrambler #(
        .WIDTH (8),
        .SEED  (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sync      (sync),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w0     (in_w0),
        .in_w1     (in_w1),
        .in_par    (in_par),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_u0    (out_u0),
        .out_u1    (out_u1),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] stepModel(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Monitor: compare popped beats first, then record the beat being accepted.
    always @(negedge clk) begin
        logic [15:0] exp_beat;
        logic [15:0] k;
        logic [7:0]  e0;
        logic [7:0]  e1;
        if (rst) begin
            sb.delete();
            model_lfsr = SEED;
            model_err  = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    exp_beat = sb.pop_front();
                    checkOutput("sb_u0", {24'd0, out_u0}, {24'd0, exp_beat[15:8]});
                    checkOutput("sb_u1", {24'd0, out_u1}, {24'd0, exp_beat[7:0]});
                end
            end
            if (in_valid && in_ready) begin
                k  = sync ? SEED : model_lfsr;
                e0 = in_w0 ^ k[7:0];
                e1 = in_w1 ^ k[15:8];
                sb.push_back({e0, e1});
                model_err = model_err + int'((^e0) != in_par[0]) + int'((^e1) != in_par[1]);
                if (model_err > 255) model_err = 255;
                model_lfsr = stepModel(k);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitAccept();
        int n = 0;
        while (!in_ready) begin
            if (n >= 50) begin
                checkOutput("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                sync     = 1'b0;
                return;
            end
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        sync     = 1'b0;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1,
                                 input logic [1:0] par, input logic syn);
        in_w0    = w0;
        in_w1    = w1;
        in_par   = par;
        sync     = syn;
        in_valid = 1'b1;
        waitAccept();
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        sync     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic checkErr(input string tag, input int want_en);
`ifdef LANE_DESCRAMBLER_PARITY_CHECK_EN
        checkOutput(tag, {24'd0, err_cnt}, want_en);
`else
        checkOutput(tag, {24'd0, err_cnt}, 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] k;
        logic [7:0]  w0;
        logic [7:0]  w1;
        rst = 1'b1; sync = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_w0 = '0; in_w1 = '0; in_par = '0;

        // Reset state
        doReset();
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_u0", {24'd0, out_u0}, 32'd0);
        checkOutput("rst_u1", {24'd0, out_u1}, 32'd0);
        checkOutput("rst_err", {24'd0, err_cnt}, 32'd0);

        // First two beats with known keys
        applyStimulus(8'hE1, 8'hAC, 2'b00, 1'b0);
        checkOutput("lat_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("b1_u0", {24'd0, out_u0}, 32'h00);
        checkOutput("b1_u1", {24'd0, out_u1}, 32'h00);
        applyStimulus(8'h70, 8'hE2, 2'b00, 1'b0);
        checkOutput("b2_u0", {24'd0, out_u0}, 32'h00);
        checkOutput("b2_u1", {24'd0, out_u1}, 32'h00);
        drain();

        // Backpressure: third beat held until the consumer drains
        doReset();
        out_ready = 1'b0;
        applyStimulus(8'hE1 ^ 8'h11, 8'hAC ^ 8'h22, 2'b00, 1'b0);
        checkOutput("bp_ready_a", {31'd0, in_ready}, 32'd1);
        applyStimulus(8'h70 ^ 8'h33, 8'hE2 ^ 8'h44, 2'b00, 1'b0);
        checkOutput("bp_ready_b", {31'd0, in_ready}, 32'd0);
        in_w0 = 8'h5A; in_w1 = 8'hC3; in_par = 2'b00; in_valid = 1'b1;
        repeat (3) tick();
        checkOutput("bp_held", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_hold_u0", {24'd0, out_u0}, 32'h11);
        checkOutput("bp_hold_u1", {24'd0, out_u1}, 32'h22);
        out_ready = 1'b1;
        waitAccept();
        drain();

        // Sync with a concurrent beat
        doReset();
        applyStimulus(8'h12, 8'h34, 2'b00, 1'b0);
        applyStimulus(8'h56, 8'h78, 2'b00, 1'b0);
        applyStimulus(8'hFF, 8'h00, 2'b00, 1'b1);
        checkOutput("sync_u0", {24'd0, out_u0}, 32'h1E);
        checkOutput("sync_u1", {24'd0, out_u1}, 32'hAC);
        applyStimulus(8'h70, 8'hE2, 2'b00, 1'b0);
        checkOutput("post_sync_u0", {24'd0, out_u0}, 32'h00);
        checkOutput("post_sync_u1", {24'd0, out_u1}, 32'h00);
        drain();

        // Reset while both buffer entries are full
        out_ready = 1'b0;
        applyStimulus(8'h01, 8'h02, 2'b00, 1'b0);
        applyStimulus(8'h03, 8'h04, 2'b00, 1'b0);
        checkOutput("two_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        checkOutput("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(8'hE1, 8'hAC, 2'b00, 1'b0);
        checkOutput("rst2_u0", {24'd0, out_u0}, 32'h00);
        checkOutput("rst2_u1", {24'd0, out_u1}, 32'h00);

        // Idle cycles must not advance the keystream
        repeat (5) tick();
        applyStimulus(8'h70, 8'hE2, 2'b00, 1'b0);
        checkOutput("stall_u0", {24'd0, out_u0}, 32'h00);
        checkOutput("stall_u1", {24'd0, out_u1}, 32'h00);
        drain();

        // Random traffic with random backpressure and occasional sync
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom), 8'($urandom), 2'($urandom),
                          1'($urandom_range(0, 7) == 0));
        end
        rand_mode = 1'b0;
        drain();

        // Parity: one erroring lane, then saturation
        doReset();
        applyStimulus(8'hE0, 8'hAC, 2'b00, 1'b0);
        tick();
        checkErr("par_one", 1);
        for (int i = 0; i < 300; i++) begin
            w0 = 8'($urandom);
            w1 = 8'($urandom);
            k  = model_lfsr;
            applyStimulus(w0, w1, {~^(w1 ^ k[15:8]), ~^(w0 ^ k[7:0])}, 1'b0);
        end
        tick();
        checkErr("par_sat", 255);
        checkErr("par_model", model_err);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
